// File: rtl/modsq_final_subtract_if.sv
// Handshake bundle between the Montgomery squaring adder stage and the final
// conditional-subtract stage: an input channel (x, m) and an output channel (result).
interface modsq_final_subtract_if #(
    parameter int WIDTH = 1024
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH:0]   x;
    logic [WIDTH-1:0] m;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             out_subtracted;

    modport slave (
        input  in_valid, x, m, out_ready,
        output in_ready, out_valid, result, out_subtracted
    );

    modport master (
        output in_valid, x, m, out_ready,
        input  in_ready, out_valid, result, out_subtracted
    );
endinterface

// File: rtl/modsq_final_subtract.sv
// Final reduction of the Montgomery squaring sum: result = (x >= M) ? x - M : x,
// computed as a chunk-serial LSB-first subtraction so no full-width borrow chain exists.
module modsq_final_subtract #(
    parameter int WIDTH = 1024,
    parameter int CHUNK = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    modsq_final_subtract_if.slave  bus
);
    localparam int NUM_CHUNKS = (WIDTH + CHUNK - 1) / CHUNK;
    localparam int PADW       = NUM_CHUNKS * CHUNK;
    localparam int CW         = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [CW-1:0] LAST_CHUNK = CW'(NUM_CHUNKS - 1);

    typedef enum logic [1:0] {
        IDLE,
        SUB,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [PADW-1:0]  xPad_q, xPad_d;
    logic [PADW-1:0]  mPad_q, mPad_d;
    logic [PADW-1:0]  diff_q, diff_d;
    logic             xCarry_q, xCarry_d;
    logic             borrow_q, borrow_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             subtracted_q, subtracted_d;

    logic [CHUNK-1:0] xChunk;
    logic [CHUNK-1:0] mChunk;
    logic [CHUNK-1:0] dChunk;
    logic             borrowOut;
    logic             ge;

    // One chunk of the running subtraction; the top bit of the widened difference is the borrow.
    assign xChunk = xPad_q[int'(count_q) * CHUNK +: CHUNK];
    assign mChunk = mPad_q[int'(count_q) * CHUNK +: CHUNK];
    assign {borrowOut, dChunk} = {1'b0, xChunk} - {1'b0, mChunk} - {{CHUNK{1'b0}}, borrow_q};

    // The adder carry alone guarantees x >= M; otherwise the final borrow decides.
    assign ge = xCarry_q | ~borrowOut;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            xPad_q       <= '0;
            mPad_q       <= '0;
            diff_q       <= '0;
            xCarry_q     <= 1'b0;
            borrow_q     <= 1'b0;
            count_q      <= '0;
            result_q     <= '0;
            subtracted_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            xPad_q       <= xPad_d;
            mPad_q       <= mPad_d;
            diff_q       <= diff_d;
            xCarry_q     <= xCarry_d;
            borrow_q     <= borrow_d;
            count_q      <= count_d;
            result_q     <= result_d;
            subtracted_q <= subtracted_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        xPad_d       = xPad_q;
        mPad_d       = mPad_q;
        diff_d       = diff_q;
        xCarry_d     = xCarry_q;
        borrow_d     = borrow_q;
        count_d      = count_q;
        result_d     = result_q;
        subtracted_d = subtracted_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    xPad_d              = '0;
                    xPad_d[WIDTH-1:0]   = bus.x[WIDTH-1:0];
                    mPad_d              = '0;
                    mPad_d[WIDTH-1:0]   = bus.m;
                    xCarry_d            = bus.x[WIDTH];
                    diff_d              = '0;
                    borrow_d            = 1'b0;
                    count_d             = '0;
                    state_d             = SUB;
                end
            end

            SUB: begin
                diff_d[int'(count_q) * CHUNK +: CHUNK] = dChunk;
                borrow_d = borrowOut;
                if (count_q == LAST_CHUNK) begin
                    // diff_d already holds the final chunk, so the decision uses the complete difference.
                    result_d     = ge ? diff_d[WIDTH-1:0] : xPad_q[WIDTH-1:0];
                    subtracted_d = ge;
                    count_d      = '0;
                    state_d      = DONE;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end

            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.in_ready       = (state_q == IDLE);
    assign bus.out_valid      = (state_q == DONE);
    assign bus.result         = result_q;
    assign bus.out_subtracted = subtracted_q;

endmodule
